// File: rtl/cache_fill_fsm_pkg.sv
// Shared cache definitions: fill FSM state encoding, cache geometry and
// byte-address field positions used by the fill FSM, hit logic and access decoder.
package cache_fill_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fill_state_e;

  localparam int TAG_W  = 5;
  localparam int SET_W  = 7;
  localparam int WORD_W = 3;

  localparam int TAG_HI  = 15;
  localparam int TAG_LO  = 11;
  localparam int SET_HI  = 10;
  localparam int SET_LO  = 4;
  localparam int WORD_HI = 3;
  localparam int WORD_LO = 1;

  // Word-aligned byte address of one word within a block.
  function automatic logic [TAG_W+SET_W+WORD_W:0] word_addr(
    input logic [TAG_W-1:0]  tag,
    input logic [SET_W-1:0]  set,
    input logic [WORD_W-1:0] word
  );
    return {tag, set, word, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// fill_word_counter: word-index counter with clear, enable and terminal-count
// flag; one tracks issued requests, the other returned words.
module fill_word_counter
  import cache_fill_fsm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [WORD_W-1:0] cnt_o,
  output logic              tc_o
);

  logic [WORD_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '1);

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: eight sequential word reads per miss, in-order writes
// into the data array, tag write on the last word. Optional CACHE_FILL_STATS_EN adds fill_count.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int SET_W  = 7,
  parameter int WORD_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data_in,
  output logic              fsm_busy,
  output logic              memory_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic [SET_W-1:0]  fill_set,
  output logic [WORD_W-1:0] word_offset,
  output logic              write_data_array,
  output logic [15:0]       fill_data,
  output logic              write_tag_array,
  output logic [TAG_W-1:0]  fill_tag
`ifdef CACHE_FILL_STATS_EN
  ,
  output logic [15:0]       fill_count
`endif
);

  fill_state_e       state_q;
  logic              busy_q, mem_read_q, wr_data_q, wr_tag_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [SET_W-1:0]  fill_set_q;
  logic [WORD_W-1:0] word_offset_q;
  logic [15:0]       fill_data_q;
  logic [TAG_W-1:0]  fill_tag_q;
  logic [3:0]        iss_tot_q, rcv_tot_q;

  logic              start, req_en, rcv_en, req_tc, rcv_tc;
  logic [WORD_W-1:0] req_cnt, rcv_cnt;
  logic              unused_addr_bits;

  // The faulting word/byte offset never steers the fill order.
  assign unused_addr_bits = ^miss_address[WORD_HI:0];

  assign start  = (state_q == ST_IDLE) && miss_detected;
  assign req_en = (state_q == ST_REQ) && mem_read_q && !iss_tot_q[3];
  assign rcv_en = (state_q != ST_IDLE) && memory_data_valid && !rcv_tot_q[3] && !wr_tag_q;

  fill_word_counter u_req_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start),
    .en_i  (req_en),
    .cnt_o (req_cnt),
    .tc_o  (req_tc)
  );

  fill_word_counter u_rcv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start),
    .en_i  (rcv_en),
    .cnt_o (rcv_cnt),
    .tc_o  (rcv_tc)
  );

`ifdef CACHE_FILL_STATS_EN
  logic [15:0] fill_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_count_q <= '0;
    end else if (rcv_en && rcv_tc) begin
      fill_count_q <= fill_count_q + 16'd1;
    end
  end

  assign fill_count = fill_count_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      mem_read_q    <= 1'b0;
      wr_data_q     <= 1'b0;
      wr_tag_q      <= 1'b0;
      mem_addr_q    <= '0;
      fill_set_q    <= '0;
      word_offset_q <= '0;
      fill_data_q   <= '0;
      fill_tag_q    <= '0;
      iss_tot_q     <= '0;
      rcv_tot_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wr_data_q <= 1'b0;
          wr_tag_q  <= 1'b0;
          if (miss_detected) begin
            state_q    <= ST_REQ;
            busy_q     <= 1'b1;
            mem_read_q <= 1'b1;
            fill_tag_q <= miss_address[TAG_HI:TAG_LO];
            fill_set_q <= miss_address[SET_HI:SET_LO];
            mem_addr_q <= word_addr(miss_address[TAG_HI:TAG_LO],
                                    miss_address[SET_HI:SET_LO], '0);
            iss_tot_q  <= '0;
            rcv_tot_q  <= '0;
          end
        end
        default: begin
          if (wr_tag_q) begin
            // Final write cycle just presented: release the pipeline.
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            mem_read_q <= 1'b0;
            wr_data_q  <= 1'b0;
            wr_tag_q   <= 1'b0;
          end else begin
            if (req_en) begin
              iss_tot_q <= iss_tot_q + 4'd1;
              if (req_tc) begin
                mem_read_q <= 1'b0;
              end else begin
                mem_addr_q <= word_addr(fill_tag_q, fill_set_q, req_cnt + 3'd1);
              end
            end
            wr_data_q <= rcv_en;
            if (rcv_en) begin
              fill_data_q   <= memory_data_in;
              word_offset_q <= rcv_cnt;
              rcv_tot_q     <= rcv_tot_q + 4'd1;
              wr_tag_q      <= rcv_tc;
            end
            // Zero-latency memory finishes together with the last request: skip DRAIN.
            if (req_en && req_tc && !(rcv_en && rcv_tc)) begin
              state_q <= ST_DRAIN;
            end
          end
        end
      endcase
    end
  end

  assign fsm_busy         = busy_q;
  assign memory_read      = mem_read_q;
  assign memory_address   = mem_addr_q;
  assign fill_set         = fill_set_q;
  assign word_offset      = word_offset_q;
  assign write_data_array = wr_data_q;
  assign fill_data        = fill_data_q;
  assign write_tag_array  = wr_tag_q;
  assign fill_tag         = fill_tag_q;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm; cycle 0 is the cycle a miss is presented.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data_in = '0;
  logic        fsm_busy, memory_read, write_data_array, write_tag_array;
  logic [15:0] memory_address, fill_data;
  logic [6:0]  fill_set;
  logic [2:0]  word_offset;
  logic [4:0]  fill_tag;
`ifdef CACHE_FILL_STATS_EN
  logic [15:0] fill_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data_in    (memory_data_in),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .fill_set          (fill_set),
    .word_offset       (word_offset),
    .write_data_array  (write_data_array),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array),
    .fill_tag          (fill_tag)
`ifdef CACHE_FILL_STATS_EN
    ,
    .fill_count        (fill_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [51:0] got;
    rst = 1'b1;
    tick();
    tick();
    got = {fsm_busy, memory_read, write_data_array, write_tag_array, memory_address,
           fill_set, word_offset, fill_data, fill_tag};
    checks++;
    if (got !== 52'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h want 0", got);
    end
`ifdef CACHE_FILL_STATS_EN
    checks++;
    if (fill_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_fill_count: got %0d want 0", fill_count);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency4();
    logic [3:0] ctl, exp_ctl;
    miss_address = 16'h1234;
    miss_detected = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      tick();
      miss_detected = 1'b0;
      memory_data_valid = (n >= 5 && n <= 12);
      memory_data_in = 16'hA000 + 16'(n - 5);
      ctl = {fsm_busy, memory_read, write_data_array, write_tag_array};
      exp_ctl = {n <= 13, n <= 8, n >= 6 && n <= 13, n == 13};
      checks++;
      if (ctl !== exp_ctl) begin
        errors++;
        $display("FAIL lat4_ctl cycle %0d: got %b want %b", n, ctl, exp_ctl);
      end
      if (n <= 8) begin
        checks++;
        if (memory_address !== 16'h1230 + 16'(2 * (n - 1))) begin
          errors++;
          $display("FAIL lat4_addr cycle %0d: got %h want %h", n, memory_address,
                   16'h1230 + 16'(2 * (n - 1)));
        end
      end
      if (n >= 6 && n <= 13) begin
        checks++;
        if ({fill_set, word_offset, fill_data} !== {7'h23, 3'(n - 6), 16'hA000 + 16'(n - 6)}) begin
          errors++;
          $display("FAIL lat4_write cycle %0d: got set %h off %0d data %h want set 23 off %0d data %h",
                   n, fill_set, word_offset, fill_data, n - 6, 16'hA000 + 16'(n - 6));
        end
      end
      if (n == 13) begin
        checks++;
        if (fill_tag !== 5'h02) begin
          errors++;
          $display("FAIL lat4_tag: got %h want 02", fill_tag);
        end
      end
    end
    memory_data_valid = 1'b0;
  endtask

  task automatic test_zero_latency();
    logic [3:0] ctl, exp_ctl;
    miss_address = 16'h1234;
    miss_detected = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      miss_detected = 1'b0;
      memory_data_valid = (n <= 8);
      memory_data_in = 16'h5000 + 16'(n - 1);
      ctl = {fsm_busy, memory_read, write_data_array, write_tag_array};
      exp_ctl = {n <= 9, n <= 8, n >= 2 && n <= 9, n == 9};
      checks++;
      if (ctl !== exp_ctl) begin
        errors++;
        $display("FAIL zlat_ctl cycle %0d: got %b want %b", n, ctl, exp_ctl);
      end
      if (n >= 2 && n <= 9) begin
        checks++;
        if ({word_offset, fill_data} !== {3'(n - 2), 16'h5000 + 16'(n - 2)}) begin
          errors++;
          $display("FAIL zlat_write cycle %0d: got off %0d data %h want off %0d data %h",
                   n, word_offset, fill_data, n - 2, 16'h5000 + 16'(n - 2));
        end
      end
    end
    memory_data_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ctl, exp_ctl;
    miss_address = 16'h1234;
    miss_detected = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 10) miss_address = 16'hFFF0;
      if (n == 12) miss_detected = 1'b0;
      memory_data_valid = (n <= 8) || (n >= 11 && n <= 18);
      memory_data_in = 16'h7700 + 16'(n);
      ctl = {fsm_busy, memory_read, write_data_array, write_tag_array};
      exp_ctl = {n != 10 && n != 20, n <= 8 || (n >= 11 && n <= 18),
                 (n >= 2 && n <= 9) || (n >= 12 && n <= 19), n == 9 || n == 19};
      checks++;
      if (ctl !== exp_ctl) begin
        errors++;
        $display("FAIL b2b_ctl cycle %0d: got %b want %b", n, ctl, exp_ctl);
      end
      if (n == 5) begin
        checks++;
        if ({fill_set, fill_tag} !== {7'h23, 5'h02}) begin
          errors++;
          $display("FAIL b2b_first_ignored: got set %h tag %h want set 23 tag 02", fill_set, fill_tag);
        end
      end
      if (n == 11 || n == 19) begin
        checks++;
        if ({fill_set, fill_tag} !== {7'h7F, 5'h1F}) begin
          errors++;
          $display("FAIL b2b_second cycle %0d: got set %h tag %h want set 7f tag 1f",
                   n, fill_set, fill_tag);
        end
      end
      if (n == 11) begin
        checks++;
        if (memory_address !== 16'hFFF0) begin
          errors++;
          $display("FAIL b2b_second_addr: got %h want fff0", memory_address);
        end
      end
    end
    memory_data_valid = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    logic [51:0] got;
    logic [2:0]  idle_ctl;
    miss_address = 16'h1234;
    miss_detected = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      miss_detected = 1'b0;
      memory_data_valid = (n >= 5 && n <= 7);
      memory_data_in = 16'hC000 + 16'(n);
    end
    checks++;
    if ({write_data_array, word_offset} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL rstmid_pre: got wr %b off %0d want wr 1 off 2", write_data_array, word_offset);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = {fsm_busy, memory_read, write_data_array, write_tag_array, memory_address,
           fill_set, word_offset, fill_data, fill_tag};
    checks++;
    if (got !== 52'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %0h want 0", got);
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      idle_ctl = {fsm_busy, write_data_array, write_tag_array};
      checks++;
      if (idle_ctl !== 3'b000) begin
        errors++;
        $display("FAIL rstmid_no_tag step %0d: got %b want 000", n, idle_ctl);
      end
    end
  endtask

  task automatic test_spurious_valid();
    logic [2:0] ctl;
    memory_data_valid = 1'b1;
    memory_data_in = 16'hDEAD;
    for (int n = 0; n < 3; n++) begin
      tick();
      ctl = {fsm_busy, memory_read, write_data_array};
      checks++;
      if (ctl !== 3'b000) begin
        errors++;
        $display("FAIL spurious step %0d: got %b want 000", n, ctl);
      end
    end
    memory_data_valid = 1'b0;
    tick();
  endtask

  task automatic test_stats();
    int pulses = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      miss_address = 16'h0800 * 16'(f + 1);
      miss_detected = 1'b1;
      for (int n = 1; n <= 10; n++) begin
        tick();
        miss_detected = 1'b0;
        memory_data_valid = (n <= 8);
        memory_data_in = 16'(f * 16 + n);
        if (write_tag_array === 1'b1) pulses++;
      end
    end
    memory_data_valid = 1'b0;
    checks++;
    if ({pulses == 3, fsm_busy, fill_tag} !== {1'b1, 1'b0, 5'h03}) begin
      errors++;
      $display("FAIL stats_fills: got pulses %0d busy %b tag %h want 3 0 03", pulses, fsm_busy, fill_tag);
    end
`ifdef CACHE_FILL_STATS_EN
    checks++;
    if (fill_count !== 16'd3) begin
      errors++;
      $display("FAIL stats_count: got %0d want 3", fill_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_latency4();
    test_zero_latency();
    test_back_to_back();
    test_reset_mid_fill();
    test_spurious_valid();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
